// File: rtl/segre_fetch_redirect.sv
// Fetch PC owner with single-outstanding instruction-memory requests and a
// one-entry decode output register; taken branches flush and redirect fetch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | post-reset idle cycle, no request, responses ignored
// REQ      | request at pc outstanding (or draining a stale one if drop)
// WAIT_DEC | output register full and decode stalled, no request
module segre_fetch_redirect #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 br_valid_i,
    input  logic                 tkbr_i,
    input  logic [WORD_SIZE-1:0] br_target_i,
    input  logic                 stall_i,
    output logic                 if_req_o,
    output logic [WORD_SIZE-1:0] if_addr_o,
    input  logic                 if_rvalid_i,
    input  logic [WORD_SIZE-1:0] if_instr_i,
    output logic                 instr_valid_o,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [WORD_SIZE-1:0] instr_pc_o,
    output logic                 flush_o,
    output logic                 misalign_o
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        REQ      = 2'd1,
        WAIT_DEC = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [WORD_SIZE-1:0] pc, pc_n;
    logic                 drop, drop_n;
    logic                 valid_n;
    logic [WORD_SIZE-1:0] instr_n;
    logic [WORD_SIZE-1:0] instr_pc_n;

    logic                 redir;
    logic [WORD_SIZE-1:0] redir_pc;
    logic [WORD_SIZE-1:0] pc_inc;

    assign redir    = br_valid_i & tkbr_i;
    assign redir_pc = {br_target_i[WORD_SIZE-1:2], 2'b00};
    assign pc_inc   = pc + WORD_SIZE'(4);

    assign flush_o    = redir;
    assign misalign_o = redir & (br_target_i[1:0] != 2'b00);
    assign if_req_o   = (state == REQ) & ~drop;
    assign if_addr_o  = pc;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        valid_n    = instr_valid_o;
        instr_n    = instr_o;
        instr_pc_n = instr_pc_o;

        // decode takes the held instruction whenever it is not stalled
        if (instr_valid_o && !stall_i) begin
            valid_n = 1'b0;
        end

        case (state)
            BOOT: begin
                state_n = REQ;
            end
            REQ: begin
                if (drop) begin
                    if (if_rvalid_i) begin
                        drop_n = 1'b0;
                    end
                end else if (if_rvalid_i && !redir) begin
                    valid_n    = 1'b1;
                    instr_n    = if_instr_i;
                    instr_pc_n = pc;
                    pc_n       = pc_inc;
                    state_n    = stall_i ? WAIT_DEC : REQ;
                end else if (!if_rvalid_i && redir) begin
                    // old request still in flight: swallow its response first
                    drop_n = 1'b1;
                end
            end
            WAIT_DEC: begin
                if (!stall_i) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase

        if (redir) begin
            pc_n    = redir_pc;
            valid_n = 1'b0;
            state_n = REQ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= BOOT;
            pc            <= BOOT_ADDR;
            drop          <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            drop          <= drop_n;
            instr_valid_o <= valid_n;
            instr_o       <= instr_n;
            instr_pc_o    <= instr_pc_n;
        end
    end

endmodule

// File: tb/tb_segre_fetch_redirect.sv
// Cycle-by-cycle directed vectors for segre_fetch_redirect, with the
// instruction-memory response driven straight from the vector table.
module tb_segre_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        tkbr;
    logic [31:0] br_target;
    logic        stall;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_instr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    segre_fetch_redirect #(
        .WORD_SIZE (32),
        .BOOT_ADDR (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .br_valid_i    (br_valid),
        .tkbr_i        (tkbr),
        .br_target_i   (br_target),
        .stall_i       (stall),
        .if_req_o      (if_req),
        .if_addr_o     (if_addr),
        .if_rvalid_i   (if_rvalid),
        .if_instr_i    (if_instr),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .flush_o       (flush),
        .misalign_o    (misalign)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        brv;
        logic        tk;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst_v, stall_v, brv_v, tk_v,
                                input logic [31:0] tgt_v,
                                input logic rv_v,
                                input logic [31:0] rd_v,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep,
                                input logic ef, input logic em);
        vec_t v;
        v.rst = rst_v;   v.stall = stall_v; v.brv = brv_v; v.tk = tk_v;
        v.tgt = tgt_v;   v.rv = rv_v;       v.rdata = rd_v;
        v.e_req = er;    v.e_addr = ea;     v.e_valid = ev;
        v.e_instr = ei;  v.e_pc = ep;       v.e_flush = ef; v.e_mis = em;
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        stall     = v.stall;
        br_valid  = v.brv;
        tkbr      = v.tk;
        br_target = v.tgt;
        if_rvalid = v.rv;
        if_instr  = v.rdata;
    endtask

    task automatic check_all(input vec_t v, input int row);
        check("if_req",      row, 32'(if_req),      32'(v.e_req));
        check("if_addr",     row, if_addr,          v.e_addr);
        check("instr_valid", row, 32'(instr_valid), 32'(v.e_valid));
        check("instr",       row, instr,            v.e_instr);
        check("instr_pc",    row, instr_pc,         v.e_pc);
        check("flush",       row, 32'(flush),       32'(v.e_flush));
        check("misalign",    row, 32'(misalign),    32'(v.e_mis));
    endtask

    initial begin
        vec_t v;
        // rst stall brv tk tgt rv rdata | req addr valid instr pc flush mis
        vecs[0]  = mk(0,0,0,0,32'h0,0,32'h0,                 0,32'h0,0,32'h0,32'h0,0,0);
        vecs[1]  = mk(0,0,0,0,32'h0,1,32'h1000_0000,         1,32'h0,0,32'h0,32'h0,0,0);
        vecs[2]  = mk(0,0,0,0,32'h0,1,32'h1000_0004,         1,32'h4,1,32'h1000_0000,32'h0,0,0);
        vecs[3]  = mk(0,1,0,0,32'h0,1,32'h1000_0008,         1,32'h8,1,32'h1000_0004,32'h4,0,0);
        vecs[4]  = mk(0,1,0,0,32'h0,0,32'h0,                 0,32'hC,1,32'h1000_0008,32'h8,0,0);
        vecs[5]  = mk(0,1,0,0,32'h0,0,32'h0,                 0,32'hC,1,32'h1000_0008,32'h8,0,0);
        vecs[6]  = mk(0,1,0,0,32'h0,0,32'h0,                 0,32'hC,1,32'h1000_0008,32'h8,0,0);
        vecs[7]  = mk(0,0,0,0,32'h0,0,32'h0,                 0,32'hC,1,32'h1000_0008,32'h8,0,0);
        vecs[8]  = mk(0,0,0,0,32'h0,0,32'h0,                 1,32'hC,0,32'h1000_0008,32'h8,0,0);
        vecs[9]  = mk(0,0,0,0,32'h0,1,32'h1000_000C,         1,32'hC,0,32'h1000_0008,32'h8,0,0);
        vecs[10] = mk(0,0,0,0,32'h0,0,32'h0,                 1,32'h10,1,32'h1000_000C,32'hC,0,0);
        vecs[11] = mk(0,0,1,1,32'h100,0,32'h0,               1,32'h10,0,32'h1000_000C,32'hC,1,0);
        vecs[12] = mk(0,0,0,0,32'h0,0,32'h0,                 0,32'h100,0,32'h1000_000C,32'hC,0,0);
        vecs[13] = mk(0,0,0,0,32'h0,1,32'hDEAD_0010,         0,32'h100,0,32'h1000_000C,32'hC,0,0);
        vecs[14] = mk(0,0,0,0,32'h0,1,32'h1000_0100,         1,32'h100,0,32'h1000_000C,32'hC,0,0);
        vecs[15] = mk(0,0,1,1,32'h200,1,32'h1000_0104,       1,32'h104,1,32'h1000_0100,32'h100,1,0);
        vecs[16] = mk(0,1,0,0,32'h0,1,32'h1000_0200,         1,32'h200,0,32'h1000_0100,32'h100,0,0);
        vecs[17] = mk(0,1,1,1,32'h203,0,32'h0,               0,32'h204,1,32'h1000_0200,32'h200,1,1);
        vecs[18] = mk(0,1,0,0,32'h0,0,32'h0,                 1,32'h200,0,32'h1000_0200,32'h200,0,0);
        vecs[19] = mk(0,0,0,0,32'h0,1,32'h2000_0200,         1,32'h200,0,32'h1000_0200,32'h200,0,0);
        vecs[20] = mk(0,0,1,0,32'h300,1,32'h2000_0204,       1,32'h204,1,32'h2000_0200,32'h200,0,0);
        vecs[21] = mk(0,0,1,0,32'h303,0,32'h0,               1,32'h208,1,32'h2000_0204,32'h204,0,0);
        vecs[22] = mk(0,0,1,1,32'hFFFF_FFFC,0,32'h0,         1,32'h208,0,32'h2000_0204,32'h204,1,0);
        vecs[23] = mk(0,0,0,0,32'h0,1,32'h0BAD_0000,         0,32'hFFFF_FFFC,0,32'h2000_0204,32'h204,0,0);
        vecs[24] = mk(0,0,0,0,32'h0,1,32'h3000_0000,         1,32'hFFFF_FFFC,0,32'h2000_0204,32'h204,0,0);
        vecs[25] = mk(0,0,0,0,32'h0,0,32'h0,                 1,32'h0,1,32'h3000_0000,32'hFFFF_FFFC,0,0);
        vecs[26] = mk(0,0,1,1,32'h40,0,32'h0,                1,32'h0,0,32'h3000_0000,32'hFFFF_FFFC,1,0);
        vecs[27] = mk(0,0,1,1,32'h80,0,32'h0,                0,32'h40,0,32'h3000_0000,32'hFFFF_FFFC,1,0);
        vecs[28] = mk(0,0,0,0,32'h0,1,32'h0BAD_0001,         0,32'h80,0,32'h3000_0000,32'hFFFF_FFFC,0,0);
        vecs[29] = mk(0,0,0,0,32'h0,1,32'h4000_0080,         1,32'h80,0,32'h3000_0000,32'hFFFF_FFFC,0,0);
        vecs[30] = mk(0,0,0,0,32'h0,0,32'h0,                 1,32'h84,1,32'h4000_0080,32'h80,0,0);
        vecs[31] = mk(1,0,0,0,32'h0,0,32'h0,                 1,32'h84,0,32'h4000_0080,32'h80,0,0);
        vecs[32] = mk(0,0,0,0,32'h0,1,32'h0BAD_0002,         0,32'h0,0,32'h0,32'h0,0,0);
        vecs[33] = mk(0,0,0,0,32'h0,1,32'h5000_0000,         1,32'h0,0,32'h0,32'h0,0,0);
        vecs[34] = mk(0,0,0,0,32'h0,0,32'h0,                 1,32'h4,1,32'h5000_0000,32'h0,0,0);

        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; tkbr = 1'b0;
        br_target = 32'h0; if_rvalid = 1'b0; if_instr = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_all(vecs[i], i);
        end

        // Redirect taken while in BOOT goes straight to a request at the target
        @(negedge clk);
        v = mk(1,0,0,0,32'h0,0,32'h0, 0,32'h0,0,32'h0,32'h0,0,0);
        drive(v);
        @(negedge clk);
        v = mk(0,0,1,1,32'h502,0,32'h0, 0,32'h0,0,32'h0,32'h0,1,1);
        drive(v);
        #1;
        check_all(v, 100);
        @(negedge clk);
        v = mk(0,0,0,0,32'h0,1,32'h6000_0500, 1,32'h500,0,32'h0,32'h0,0,0);
        drive(v);
        #1;
        check_all(v, 101);
        @(negedge clk);
        v = mk(0,0,0,0,32'h0,0,32'h0, 1,32'h504,1,32'h6000_0500,32'h500,0,0);
        drive(v);
        #1;
        check_all(v, 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
